// File: rtl/tilemap_cmd_sequencer_pkg.sv
// Shared definitions for the tilemap command sequencer: command codes, register
// indices, FSM states and status bit positions.
package tilemap_seq_pkg;

   localparam logic [2:0] CMD_SCROLL_LEFT  = 3'd1;
   localparam logic [2:0] CMD_SCROLL_RIGHT = 3'd2;
   localparam logic [2:0] CMD_SCROLL_UP    = 3'd3;
   localparam logic [2:0] CMD_SCROLL_DOWN  = 3'd4;
   localparam logic [2:0] CMD_CLEAR        = 3'd5;

   localparam logic [1:0] REG_OFFSET_X = 2'd0;
   localparam logic [1:0] REG_OFFSET_Y = 2'd1;
   localparam logic [1:0] REG_TRIGGER  = 2'd2;
   localparam logic [1:0] REG_SEQCTL   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_VBL = 2'd1,
      ST_ISSUE    = 2'd2,
      ST_POLL     = 2'd3
   } seq_state_e;

   localparam int STAT_OVF     = 7;
   localparam int STAT_BAD     = 6;
   localparam int STAT_TMO     = 5;
   localparam int STAT_BUSY    = 4;
   localparam int STAT_FULL    = 3;
   localparam int STAT_CNT_LSB = 0;

   function automatic logic cmd_valid(input logic [7:0] d);
      return (d >= {5'd0, CMD_SCROLL_LEFT}) && (d <= {5'd0, CMD_CLEAR});
   endfunction

endpackage

// File: rtl/tilemap_cmd_sequencer_if.sv
// CPU-side write bus, tilemap register port and status, bundled for the sequencer.
interface tilemap_cmd_sequencer_if;

   logic       vblank;
   logic       cpu_write;
   logic [1:0] cpu_addr;
   logic [7:0] cpu_data;
   logic [7:0] tm_ctl_data_out;
   logic [1:0] tm_addr;
   logic [7:0] tm_data_in;
   logic       tm_write;
   logic [7:0] status;

   modport slave (
      input  vblank, cpu_write, cpu_addr, cpu_data, tm_ctl_data_out,
      output tm_addr, tm_data_in, tm_write, status
   );

   modport master (
      output vblank, cpu_write, cpu_addr, cpu_data, tm_ctl_data_out,
      input  tm_addr, tm_data_in, tm_write, status
   );

endinterface

// File: rtl/tilemap_cmd_sequencer_fifo.sv
// Command FIFO, DEPTH x 3 bits. Flush takes effect before a same-cycle push,
// so flush+push leaves exactly one entry at slot 0.
module tilemap_cmd_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic       i_flush,
   input  logic [2:0] i_data,
   output logic [2:0] o_head,
   output logic [2:0] o_count,
   output logic       o_full,
   output logic       o_empty
);

   localparam int PW = $clog2(DEPTH);

   logic [2:0]    r_mem [DEPTH];
   logic [PW-1:0] r_rd;
   logic [PW-1:0] r_wr;
   logic [2:0]    r_count;
   logic [PW-1:0] w_wr_at;

   assign w_wr_at = i_flush ? '0 : r_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_rd    <= '0;
         r_wr    <= i_push ? PW'(1) : '0;
         r_count <= i_push ? 3'd1 : 3'd0;
      end else begin
         if (i_pop)  r_rd <= r_rd + PW'(1);
         if (i_push) r_wr <= r_wr + PW'(1);
         r_count <= r_count + {2'd0, i_push} - {2'd0, i_pop};
      end
   end

   // Storage carries no reset; validity is tracked entirely by the pointers.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[w_wr_at] <= i_data;
   end

   assign o_head  = r_mem[r_rd];
   assign o_count = r_count;
   assign o_full  = (r_count == 3'(DEPTH));
   assign o_empty = (r_count == 3'd0);

endmodule

// File: rtl/tilemap_cmd_sequencer.sv
// Queues CPU tilemap commands and issues them one at a time to the trigger
// register during vblank, polling for completion with a timeout.
module tilemap_cmd_sequencer
   import tilemap_seq_pkg::*;
#(
   parameter int          DEPTH   = 4,
   parameter logic [23:0] TIMEOUT = 24'd4000000
) (
   input logic                     clk,
   input logic                     reset,
   tilemap_cmd_sequencer_if.slave  bus
);

   seq_state_e  r_state, w_state_nxt;
   logic [23:0] r_cnt, w_cnt_nxt;
   logic        r_ovf, r_bad, r_tmo;
   logic        w_fwd, w_enq, w_cmd_ok, w_flush, w_clr;
   logic        w_pop, w_push, w_tmo_set;
   logic [2:0]  w_head, w_count;
   logic        w_full, w_empty;
   logic        w_tm_write;
   logic [1:0]  w_tm_addr;
   logic [7:0]  w_tm_data;
   logic [7:0]  w_status;

   always_comb begin
      w_fwd    = bus.cpu_write && !reset &&
                 ((bus.cpu_addr == REG_OFFSET_X) || (bus.cpu_addr == REG_OFFSET_Y));
      w_enq    = bus.cpu_write && (bus.cpu_addr == REG_TRIGGER);
      w_cmd_ok = cmd_valid(bus.cpu_data);
      w_flush  = bus.cpu_write && (bus.cpu_addr == REG_SEQCTL) && bus.cpu_data[0];
      w_clr    = bus.cpu_write && (bus.cpu_addr == REG_SEQCTL) && bus.cpu_data[1];
   end

   // A full FIFO still accepts a command when the head leaves or is flushed this cycle.
   assign w_push = w_enq && w_cmd_ok && (!w_full || w_pop || w_flush);

   tilemap_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (bus.cpu_data[2:0]),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pop       = 1'b0;
      w_tmo_set   = 1'b0;
      w_tm_write  = 1'b0;
      w_tm_addr   = 2'd0;
      w_tm_data   = 8'd0;
      if (w_fwd) begin
         w_tm_write = 1'b1;
         w_tm_addr  = bus.cpu_addr;
         w_tm_data  = bus.cpu_data;
      end
      case (r_state)
         ST_IDLE: if (!w_empty) w_state_nxt = ST_WAIT_VBL;
         ST_WAIT_VBL: begin
            if (w_flush && !(w_enq && w_cmd_ok)) w_state_nxt = ST_IDLE;
            else if (bus.vblank)                 w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            // A same-cycle offset forward owns the port; the issue slips a cycle.
            if (!w_fwd) begin
               w_tm_write  = 1'b1;
               w_tm_addr   = REG_TRIGGER;
               w_tm_data   = {5'd0, w_head};
               w_pop       = 1'b1;
               w_cnt_nxt   = 24'd0;
               w_state_nxt = ST_POLL;
            end
         end
         ST_POLL: begin
            if (!w_fwd) w_tm_addr = REG_TRIGGER;
            if (!w_fwd && (bus.tm_ctl_data_out == 8'd0)) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 24'd1;
               if (w_cnt_nxt == TIMEOUT) begin
                  w_tmo_set   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 24'd0;
         r_ovf   <= 1'b0;
         r_bad   <= 1'b0;
         r_tmo   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_clr) begin
            r_ovf <= 1'b0;
            r_bad <= 1'b0;
            r_tmo <= 1'b0;
         end
         if (w_enq && w_cmd_ok && !w_push) r_ovf <= 1'b1;
         if (w_enq && !w_cmd_ok)           r_bad <= 1'b1;
         if (w_tmo_set)                    r_tmo <= 1'b1;
      end
   end

   always_comb begin
      w_status                       = 8'd0;
      w_status[STAT_OVF]             = r_ovf;
      w_status[STAT_BAD]             = r_bad;
      w_status[STAT_TMO]             = r_tmo;
      w_status[STAT_BUSY]            = (r_state == ST_ISSUE) || (r_state == ST_POLL);
      w_status[STAT_FULL]            = w_full;
      w_status[STAT_CNT_LSB +: 3]    = w_count;
   end

   assign bus.tm_write   = w_tm_write;
   assign bus.tm_addr    = w_tm_addr;
   assign bus.tm_data_in = w_tm_data;
   assign bus.status     = w_status;

endmodule

// File: tb/tb_tilemap_cmd_sequencer.sv
// Scoreboard bench for tilemap_cmd_sequencer with a small tilemap trigger model.
module tb_tilemap_cmd_sequencer;
   import tilemap_seq_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tilemap_cmd_sequencer_if ifc();

   tilemap_cmd_sequencer #(.DEPTH(4), .TIMEOUT(24'd16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   int checks   = 0;
   int failures = 0;
   int n_trig   = 0;
   int clr_dly  = 0;
   logic [9:0] exp_q[$];

   logic [7:0] m_reg0 = 8'd0;
   logic [7:0] m_reg1 = 8'd0;
   logic [7:0] m_reg2 = 8'd0;
   int         m_t    = 0;

   // Tilemap model: trigger register self-clears clr_dly edges after a write (0 = never).
   always @(posedge clk) begin
      if (ifc.tm_write && ifc.tm_addr == REG_OFFSET_X) m_reg0 <= ifc.tm_data_in;
      if (ifc.tm_write && ifc.tm_addr == REG_OFFSET_Y) m_reg1 <= ifc.tm_data_in;
      if (ifc.tm_write && ifc.tm_addr == REG_TRIGGER) begin
         m_reg2 <= ifc.tm_data_in;
         m_t    <= clr_dly;
      end else if (m_t != 0) begin
         m_t <= m_t - 1;
         if (m_t == 1) m_reg2 <= 8'd0;
      end
   end

   always_comb begin
      case (ifc.tm_addr)
         REG_OFFSET_X: ifc.tm_ctl_data_out = m_reg0;
         REG_OFFSET_Y: ifc.tm_ctl_data_out = m_reg1;
         REG_TRIGGER:  ifc.tm_ctl_data_out = m_reg2;
         default:      ifc.tm_ctl_data_out = 8'd0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] ev(input logic [1:0] a, input logic [7:0] d);
      return {a, d};
   endfunction

   always @(negedge clk) begin : monitor
      logic [9:0] e;
      if (!reset && ifc.tm_write) begin
         if (ifc.tm_addr == REG_TRIGGER) n_trig++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: addr=%0d data=%0h expected no write",
                     ifc.tm_addr, ifc.tm_data_in);
         end else begin
            e = exp_q.pop_front();
            chk("tm_write", 32'({ifc.tm_addr, ifc.tm_data_in}), 32'(e));
         end
      end
   end

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      ifc.cpu_write = 1'b1;
      ifc.cpu_addr  = a;
      ifc.cpu_data  = d;
      @(posedge clk); #1;
      ifc.cpu_write = 1'b0;
      ifc.cpu_addr  = 2'd0;
      ifc.cpu_data  = 8'd0;
   endtask

   task automatic wait_issue(input string name, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(ifc.tm_write && ifc.tm_addr == REG_TRIGGER) && n < 200);
      if (!(ifc.tm_write && ifc.tm_addr == REG_TRIGGER)) begin
         checks++;
         failures++;
         $display("FAIL %s: no trigger write within %0d cycles", name, n);
      end
   endtask

   task automatic busy_len(output int b);
      b = 0;
      while (ifc.status[STAT_BUSY] && b < 200) begin
         b++;
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (ifc.status != 8'h00 && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk(name, 32'(ifc.status), 32'h00);
   endtask

   initial begin : main
      int n, b, g, snap;
      reset         = 1'b1;
      ifc.vblank    = 1'b0;
      ifc.cpu_write = 1'b0;
      ifc.cpu_addr  = 2'd0;
      ifc.cpu_data  = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_status",   32'(ifc.status),     32'h00);
      chk("rst_tm_write", 32'(ifc.tm_write),   32'd0);
      chk("rst_tm_addr",  32'(ifc.tm_addr),    32'd0);
      chk("rst_tm_data",  32'(ifc.tm_data_in), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Single clear command with vblank already high
      ifc.vblank = 1'b1;
      clr_dly    = 9;
      exp_q.push_back(ev(REG_TRIGGER, 8'(CMD_CLEAR)));
      wr(REG_TRIGGER, 8'h05);
      chk("t1_count_visible", 32'(ifc.status), 32'h01);
      wait_issue("t1_issue", n);
      chk("t1_latency", 32'(n), 32'd3);
      busy_len(b);
      chk("t1_busy_cycles", 32'(b), 32'd11);
      chk("t1_idle_status", 32'(ifc.status), 32'h00);

      // Commands held off until vblank, then serialised on completion
      ifc.vblank = 1'b0;
      clr_dly    = 4;
      snap       = n_trig;
      exp_q.push_back(ev(REG_TRIGGER, 8'(CMD_SCROLL_UP)));
      exp_q.push_back(ev(REG_TRIGGER, 8'(CMD_SCROLL_LEFT)));
      wr(REG_TRIGGER, 8'h03);
      wr(REG_TRIGGER, 8'h01);
      repeat (5) @(negedge clk);
      chk("t2_no_issue", 32'(n_trig), 32'(snap));
      chk("t2_status", 32'(ifc.status), 32'h02);
      ifc.vblank = 1'b1;
      wait_issue("t2_first", n);
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!(ifc.tm_write && ifc.tm_addr == REG_TRIGGER) && g < 200);
      chk("t2_gap", 32'(g), 32'd8);
      chk("t2_reg2_clear_before_next", 32'(m_reg2), 32'd0);
      busy_len(b);
      chk("t2_busy_cycles", 32'(b), 32'd6);
      chk("t2_idle_status", 32'(ifc.status), 32'h00);

      // Overflow, sticky clear, flush
      ifc.vblank = 1'b0;
      wr(REG_TRIGGER, 8'h01);
      wr(REG_TRIGGER, 8'h02);
      wr(REG_TRIGGER, 8'h03);
      wr(REG_TRIGGER, 8'h04);
      wr(REG_TRIGGER, 8'h05);
      chk("t3_full_ovf", 32'(ifc.status), 32'h8C);
      wr(REG_SEQCTL, 8'h02);
      chk("t3_ovf_cleared", 32'(ifc.status), 32'h0C);
      wr(REG_SEQCTL, 8'h01);
      chk("t3_flushed", 32'(ifc.status), 32'h00);

      // Enqueue onto a full FIFO in the ISSUE cycle: pop then push, no overflow
      clr_dly = 2;
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back(ev(REG_TRIGGER, 8'(i)));
         wr(REG_TRIGGER, 8'(i));
      end
      ifc.vblank = 1'b1;
      exp_q.push_back(ev(REG_TRIGGER, 8'(CMD_CLEAR)));
      wr(REG_TRIGGER, 8'h05);
      chk("t3_pop_push_full", 32'(ifc.status), 32'h1C);
      wait_idle("t3_drained");

      // Bad command, then an offset write colliding with ISSUE
      wr(REG_TRIGGER, 8'h07);
      chk("t4_bad", 32'(ifc.status), 32'h40);
      clr_dly = 3;
      exp_q.push_back(ev(REG_OFFSET_X, 8'hF0));
      exp_q.push_back(ev(REG_TRIGGER, 8'(CMD_SCROLL_RIGHT)));
      wr(REG_TRIGGER, 8'h02);
      @(posedge clk);
      wr(REG_OFFSET_X, 8'hF0);
      wait_issue("t4_issue", n);
      chk("t4_issue_after_fwd", 32'(n), 32'd1);
      chk("t4_reg0", 32'(m_reg0), 32'hF0);
      busy_len(b);
      wr(REG_SEQCTL, 8'h02);
      chk("t4_bad_cleared", 32'(ifc.status), 32'h00);

      // Timeout: trigger never self-clears
      clr_dly = 0;
      exp_q.push_back(ev(REG_TRIGGER, 8'(CMD_SCROLL_DOWN)));
      exp_q.push_back(ev(REG_TRIGGER, 8'(CMD_CLEAR)));
      wr(REG_TRIGGER, 8'h04);
      wr(REG_TRIGGER, 8'h05);
      wait_issue("t5_first", n);
      busy_len(b);
      chk("t5_busy_first", 32'(b), 32'd17);
      chk("t5_tmo_status", 32'(ifc.status), 32'h21);
      wait_issue("t5_second", n);
      busy_len(b);
      chk("t5_busy_second", 32'(b), 32'd17);
      chk("t5_tmo_idle", 32'(ifc.status), 32'h20);
      wr(REG_SEQCTL, 8'h02);
      chk("t5_tmo_cleared", 32'(ifc.status), 32'h00);

      // Asynchronous reset in the middle of POLL
      exp_q.push_back(ev(REG_TRIGGER, 8'(CMD_SCROLL_UP)));
      wr(REG_TRIGGER, 8'h03);
      wr(REG_TRIGGER, 8'h01);
      wait_issue("t6_issue", n);
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("t6_async_status",   32'(ifc.status),     32'h00);
      chk("t6_async_tm_write", 32'(ifc.tm_write),   32'd0);
      chk("t6_async_tm_addr",  32'(ifc.tm_addr),    32'd0);
      chk("t6_async_tm_data",  32'(ifc.tm_data_in), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("t6_fifo_empty", 32'(ifc.status), 32'h00);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d",
               checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tilemap_cmd_sequencer.md
# tilemap_cmd_sequencer

Queues CPU tilemap control commands (scroll left/right/up/down, clear) and issues them one at a time to the tilemap's control trigger register, starting each only during vertical blank and only once the previous command has completed. It sits between the CPU write decode and the tilemap's 2-bit register port. It is the sole writer of the tilemap trigger register (index 2). Offset writes (indices 0 and 1) pass through it.

## Interface
- DEPTH, 4: command FIFO entries; legal values are 2 and 4.
- TIMEOUT, 24'd4000000: maximum number of poll cycles allowed per command before it is abandoned.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- vblank  in  1  vertical blank, level
- cpu_write  in  1  CPU write strobe, one cycle per write
- cpu_addr  in  2  CPU register index
- cpu_data  in  8  CPU write data
- tm_ctl_data_out  in  8  tilemap register readback, combinational on tm_addr
- tm_addr  out  2  tilemap register index
- tm_data_in  out  8  tilemap write data
- tm_write  out  1  tilemap write strobe
- status  out  8  {ovf, bad, tmo, busy, full, count[2:0]}

## Operation
- CPU write decode:
  - addr 0 or 1: forwarded to the tilemap in the same cycle (tm_write=1, tm_addr=cpu_addr, tm_data_in=cpu_data).
  - addr 2: enqueue. Data 1..5 is enqueued. Any other value is dropped and sets sticky bad. If the FIFO is full, the command is dropped and sets sticky ovf.
  - addr 3: bit0=1 flushes the FIFO; an in-flight command is not aborted. bit1=1 clears ovf, bad and tmo. Addr 3 writes are not forwarded.
- FSM states:
  - IDLE → WAIT_VBL when the FIFO is non-empty.
  - WAIT_VBL → ISSUE when vblank=1.
  - ISSUE:
    - If cpu_write to addr 0/1 occurs in the same cycle, the CPU wins: stay in ISSUE.
    - Otherwise drive tm_write=1, tm_addr=2, tm_data_in=FIFO head; pop the FIFO; clear the cycle counter; go to POLL.
  - POLL:
    - tm_addr=2 unless a CPU forward occurs this cycle.
    - On a cycle with no forward and tm_ctl_data_out==0, go to IDLE.
    - Otherwise increment the counter. When counter==TIMEOUT, set tmo and go to IDLE.
- If a flush empties the FIFO while in WAIT_VBL, return to IDLE.
- busy=1 in ISSUE and POLL.
- Outside forwards and ISSUE, tm_write=0; tm_addr=2 in POLL, else 0; tm_data_in=0.
- Enqueue and pop in the same cycle on a full FIFO: the pop happens first, then the enqueue is accepted; count is unchanged and ovf is not set.
- Flush and enqueue in the same cycle: the flush applies first, then the enqueue; result count=1.
- count saturates at DEPTH. FIFO pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - state=IDLE, FIFO empty.
  - All sticky flags 0.
  - tm_write=0, tm_addr=0, tm_data_in=0.
  - status=8'h00.
- Forward path is combinational: the tilemap register updates on the same edge as the CPU write.
- The enqueue becomes visible in status.count the cycle after cpu_write.
- Minimum enqueue-to-issue latency:
  - 2 cycles (IDLE→WAIT_VBL→ISSUE) when vblank is already high.
  - tm_write asserts in the 3rd cycle after the write edge.
- The first poll sample is the cycle after ISSUE. It reads the new trigger value, so the sequencer never completes early.
- Back-to-back commands leave at least 3 cycles between tm_write pulses to addr 2.
- tmo is asserted on the cycle after TIMEOUT poll cycles.
- status is registered, 1-cycle latency.

## Structure
- Package tilemap_seq_pkg:
  - command codes CMD_SCROLL_LEFT=1, CMD_SCROLL_RIGHT=2, CMD_SCROLL_UP=3, CMD_SCROLL_DOWN=4, CMD_CLEAR=5
  - register indices REG_OFFSET_X=0, REG_OFFSET_Y=1, REG_TRIGGER=2, REG_SEQCTL=3
  - FSM state encodings
  - status bit positions
- Sub-module tilemap_cmd_fifo: synchronous FIFO, DEPTH×3-bit, with push/pop/flush and count/full/empty outputs. The top level holds the FSM, timeout counter, sticky flags and forward mux.

## Test plan
- vblank=1; write addr2=8'h05; tilemap model clears reg2 after 10 cycles → exactly one tm_write to addr2 with data 5, 2 cycles after the write; busy high for 11 cycles; returns to IDLE; status=8'h00.
- vblank=0; enqueue 3, 1 → no addr2 write. Raise vblank → command 3 issued first; command 1 issued only after reg2 reads 0.
- DEPTH=4, FSM held with vblank=0; enqueue 5 commands → count=4, full=1, ovf=1. Write addr3=8'h02 → ovf=0. Write addr3=8'h01 → count=0.
- Write addr2=8'h07 → bad=1, nothing enqueued. Write addr0=8'hF0 in the same cycle as ISSUE → offset written first; ISSUE occurs one cycle later.
- TIMEOUT=16; tilemap model never clears reg2 → tmo=1 after 16 poll cycles; FSM back in IDLE; next queued command proceeds.
- Assert reset during POLL → all outputs reach their reset values asynchronously, before the next clock edge; the FIFO is empty after release.
